// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: display modes, bounce
// direction, pattern seeds and field widths.
package led_pkg;

    localparam int N_LED   = 16;
    localparam int SPEED_W = 2;

    typedef enum logic [2:0] {
        MODE_STATIC = 3'd0,
        MODE_RUN_L  = 3'd1,
        MODE_RUN_R  = 3'd2,
        MODE_BOUNCE = 3'd3,
        MODE_COUNT  = 3'd4,
        MODE_BLINK  = 3'd5,
        MODE_FILL   = 3'd6,
        MODE_OFF    = 3'd7
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [N_LED-1:0] SEED_ZERO = 16'h0000;
    localparam logic [N_LED-1:0] SEED_LOW  = 16'h0001;
    localparam logic [N_LED-1:0] SEED_HIGH = 16'h8000;

    // Pattern value loaded when a mode is newly selected.
    function automatic logic [N_LED-1:0] mode_seed(input mode_e m);
        case (m)
            MODE_RUN_L,
            MODE_BOUNCE: return SEED_LOW;
            MODE_RUN_R:  return SEED_HIGH;
            default:     return SEED_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/led_ctrl_if.sv
// Board-side signal bundle of the LED controller: switch bank in, LED drive out.
interface led_ctrl_if;
    import led_pkg::*;

    logic [7:0]       sw;
    logic [N_LED-1:0] ledr;

    modport master (output sw, input ledr);
    modport slave  (input sw, output ledr);

endinterface

// File: rtl/led_tick_gen.sv
// Animation step timer. Produces a one-cycle tick every DIV_BASE*2^speed
// clocks. The speed setting is captured only when the counter wraps or is
// cleared, so a speed change never shortens a period in flight.
module led_tick_gen
    import led_pkg::*;
#(
    parameter int DIV_BASE = 50_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SPEED_W-1:0] speed,
    input  logic               pause,
    input  logic               clear,
    output logic               tick
);

    localparam int unsigned MAX_PERIOD = DIV_BASE << ((1 << SPEED_W) - 1);
    localparam int          CNT_W      = $clog2(MAX_PERIOD);

    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   term;
    logic [SPEED_W-1:0] speed_q;

    // Terminal count for the period latched at the last wrap.
    always_comb begin
        term = CNT_W'((32'(DIV_BASE) << speed_q) - 32'd1);
    end

    assign tick = !pause && !clear && (cnt == term);

    // Count up while not paused; clear and wrap both restart and re-latch speed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            speed_q <= '0;
        end else if (clear || tick) begin
            cnt     <= '0;
            speed_q <= speed;
        end else if (!pause) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_ctrl.sv
// Switch-controlled LED pattern generator for the 16-LED bank.
// sw[2:0] mode, sw[4:3] speed, sw[5] pause, sw[6] invert, sw[7] dim.
// Optional feature: define LED_DIM_EN to enable 25% duty dimming on sw[7];
// without it sw[7] only affects the STATIC pattern.
module led_ctrl
    import led_pkg::*;
#(
    parameter int DIV_BASE = 50_000_000
) (
    input  logic     clk,
    input  logic     rst,
    led_ctrl_if.slave bus
);

    mode_e            mode;
    mode_e            prev_mode;
    logic             mode_change;
    logic             tick;
    logic [N_LED-1:0] pattern;
    logic [N_LED-1:0] pattern_next;
    dir_e             dir;
    dir_e             dir_next;
    logic [N_LED-1:0] shown;
    logic [N_LED-1:0] ledr_next;
    logic [N_LED-1:0] ledr_q;

    assign mode        = mode_e'(bus.sw[2:0]);
    assign mode_change = (mode != prev_mode);

    led_tick_gen #(
        .DIV_BASE (DIV_BASE)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .speed (bus.sw[4:3]),
        .pause (bus.sw[5]),
        .clear (mode_change),
        .tick  (tick)
    );

    // Next pattern: a mode switch reloads the seed and wins over any tick.
    always_comb begin
        pattern_next = pattern;
        dir_next     = dir;
        if (mode_change) begin
            pattern_next = mode_seed(mode);
            dir_next     = DIR_LEFT;
        end else begin
            case (mode)
                MODE_STATIC: pattern_next = {bus.sw, bus.sw};
                MODE_RUN_L:  if (tick) pattern_next = {pattern[14:0], pattern[15]};
                MODE_RUN_R:  if (tick) pattern_next = {pattern[0], pattern[15:1]};
                MODE_BOUNCE: begin
                    if (tick) begin
                        if (dir == DIR_LEFT) begin
                            if (pattern == SEED_HIGH) begin
                                pattern_next = 16'h4000;
                                dir_next     = DIR_RIGHT;
                            end else begin
                                pattern_next = {pattern[14:0], 1'b0};
                            end
                        end else begin
                            if (pattern == SEED_LOW) begin
                                pattern_next = 16'h0002;
                                dir_next     = DIR_LEFT;
                            end else begin
                                pattern_next = {1'b0, pattern[15:1]};
                            end
                        end
                    end
                end
                MODE_COUNT:  if (tick) pattern_next = pattern + 16'd1;
                MODE_BLINK:  if (tick) pattern_next = ~pattern;
                MODE_FILL: begin
                    if (tick) begin
                        pattern_next = (pattern == 16'hFFFF) ? 16'h0000 : {pattern[14:0], 1'b1};
                    end
                end
                MODE_OFF:    pattern_next = 16'h0000;
                default:     pattern_next = 16'h0000;
            endcase
        end
    end

    // Pattern, bounce direction and last-seen mode registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern   <= SEED_ZERO;
            dir       <= DIR_LEFT;
            prev_mode <= MODE_STATIC;
        end else begin
            pattern   <= pattern_next;
            dir       <= dir_next;
            prev_mode <= mode;
        end
    end

    assign shown = bus.sw[6] ? ~pattern : pattern;

`ifdef LED_DIM_EN
    logic [1:0] pwm;

    // Free-running 2-bit duty counter for the dim feature.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm <= 2'd0;
        end else begin
            pwm <= pwm + 2'd1;
        end
    end

    // Dimmed output lights only one cycle in four.
    always_comb begin
        ledr_next = shown;
        if (bus.sw[7] && (pwm != 2'd0)) begin
            ledr_next = '0;
        end
    end
`else
    // Full brightness at all times.
    always_comb begin
        ledr_next = shown;
    end
`endif

    // Registered LED drive, one clock behind the pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ledr_q <= '0;
        end else begin
            ledr_q <= ledr_next;
        end
    end

    assign bus.ledr = ledr_q;

endmodule

// File: tb/tb_led_ctrl.sv
// Self-checking bench for led_ctrl with DIV_BASE=4. A step-count model derives
// every pattern arithmetically from the number of steps since the mode was
// selected; directed literal checks pin key points of the sequence.
module tb_led_ctrl;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    led_ctrl_if bus_if ();

    led_ctrl #(
        .DIV_BASE (DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Model state
    logic [15:0] m_pat;
    logic [15:0] m_exp;
    logic [15:0] m_shown;
    logic [2:0]  m_prev;
    logic [2:0]  m_mode;
    logic [1:0]  m_pwm;
    int unsigned m_steps;
    int unsigned m_ph;
    int unsigned m_per;

    function automatic logic [15:0] seedOf(input logic [2:0] m);
        case (m)
            3'd1, 3'd3: return 16'h0001;
            3'd2:       return 16'h8000;
            default:    return 16'h0000;
        endcase
    endfunction

    // Pattern after s steps in mode m, computed directly from the step count.
    function automatic logic [15:0] patternOf(input logic [2:0] m, input int unsigned s,
                                              input logic [7:0] swv);
        int unsigned k;
        logic [31:0] w;
        case (m)
            3'd0: return {swv, swv};
            3'd1: begin w = 32'd1 << (s % 16); return w[15:0]; end
            3'd2: begin w = 32'h8000 >> (s % 16); return w[15:0]; end
            3'd3: begin
                k = s % 30;
                if (k > 15) k = 30 - k;
                w = 32'd1 << k;
                return w[15:0];
            end
            3'd4: begin w = s; return w[15:0]; end
            3'd5: return ((s % 2) == 1) ? 16'hFFFF : 16'h0000;
            3'd6: begin
                k = s % 17;
                w = (32'd1 << k) - 32'd1;
                return w[15:0];
            end
            default: return 16'h0000;
        endcase
    endfunction

    // Reference model, updated on each active edge from pre-edge inputs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pat   = 16'h0000;
            m_exp   = 16'h0000;
            m_prev  = 3'd0;
            m_steps = 0;
            m_ph    = 0;
            m_per   = DIV;
            m_pwm   = 2'd0;
        end else begin
            m_shown = bus_if.sw[6] ? ~m_pat : m_pat;
`ifdef LED_DIM_EN
            if (bus_if.sw[7] && (m_pwm != 2'd0)) m_shown = 16'h0000;
`endif
            m_exp  = m_shown;
            m_pwm  = m_pwm + 2'd1;
            m_mode = bus_if.sw[2:0];
            if (m_mode != m_prev) begin
                m_prev  = m_mode;
                m_steps = 0;
                m_ph    = 0;
                m_per   = DIV << bus_if.sw[4:3];
                m_pat   = seedOf(m_mode);
            end else begin
                if (!bus_if.sw[5]) begin
                    if (m_ph == m_per - 1) begin
                        m_ph    = 0;
                        m_steps = m_steps + 1;
                        m_per   = DIV << bus_if.sw[4:3];
                    end else begin
                        m_ph = m_ph + 1;
                    end
                end
                m_pat = patternOf(m_mode, m_steps, bus_if.sw);
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        checks++;
        if (bus_if.ledr !== m_exp) begin
            errors++;
            $display("[TB] FAIL model_cmp t=%0t ledr=%h expected=%h sw=%h",
                     $time, bus_if.ledr, m_exp, bus_if.sw);
        end
    end

    task automatic applyStimulus(input logic [7:0] v);
        bus_if.sw = v;
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] expv);
        checks++;
        if (bus_if.ledr !== expv) begin
            errors++;
            $display("[TB] FAIL %s ledr=%h expected=%h", name, bus_if.ledr, expv);
        end
    endtask

    initial begin
        bus_if.sw = 8'h00;
        #1 rst = 1'b1;
        waitClocks(2);
        checkOutput("reset", 16'h0000);
        rst = 1'b0;
        applyStimulus(8'h00);
        waitClocks(3);
        checkOutput("idle", 16'h0000);

        $display("[TB] RUN_L");
        applyStimulus(8'h01);
        waitClocks(2);  checkOutput("runl_seed", 16'h0001);
        waitClocks(4);  checkOutput("runl_step1", 16'h0002);
        waitClocks(60); checkOutput("runl_wrap", 16'h0001);

        $display("[TB] BOUNCE");
        applyStimulus(8'h03);
        waitClocks(2);  checkOutput("bounce_seed", 16'h0001);
        waitClocks(60); checkOutput("bounce_top", 16'h8000);
        waitClocks(4);  checkOutput("bounce_flip", 16'h4000);
        waitClocks(56); checkOutput("bounce_bottom", 16'h0001);
        waitClocks(4);  checkOutput("bounce_back", 16'h0002);

        $display("[TB] COUNT speed 1");
        applyStimulus(8'h0C);
        waitClocks(2);  checkOutput("count_seed", 16'h0000);
        waitClocks(8);  checkOutput("count_1", 16'h0001);
        waitClocks(8);  checkOutput("count_2", 16'h0002);
        waitClocks(40); checkOutput("count_7", 16'h0007);
        applyStimulus(8'h04);
        waitClocks(30);

        $display("[TB] FILL");
        applyStimulus(8'h06);
        waitClocks(2);  checkOutput("fill_seed", 16'h0000);
        waitClocks(64); checkOutput("fill_full", 16'hFFFF);
        waitClocks(4);  checkOutput("fill_wrap", 16'h0000);

        $display("[TB] BLINK invert + pause");
        applyStimulus(8'h45);
        waitClocks(2);  checkOutput("blink_seed", 16'hFFFF);
        waitClocks(4);  checkOutput("blink_1", 16'h0000);
        waitClocks(4);  checkOutput("blink_2", 16'hFFFF);
        applyStimulus(8'h65);
        waitClocks(20); checkOutput("blink_pause", 16'hFFFF);
        applyStimulus(8'h45);
        waitClocks(12);

        $display("[TB] STATIC");
        applyStimulus(8'h00);
        waitClocks(3);  checkOutput("static_zero", 16'h0000);
        applyStimulus(8'h58);
        waitClocks(2);  checkOutput("static_invert", 16'hA7A7);

        $display("[TB] mode change on tick");
        applyStimulus(8'h01);
        waitClocks(4);
        applyStimulus(8'h02);
        waitClocks(2);  checkOutput("collide_seed", 16'h8000);
        waitClocks(4);  checkOutput("collide_step", 16'h4000);

        $display("[TB] OFF invert");
        applyStimulus(8'h47);
        waitClocks(2);  checkOutput("off_invert", 16'hFFFF);
        applyStimulus(8'h81);
        waitClocks(10);

        $display("[TB] async reset mid-run");
        applyStimulus(8'h01);
        waitClocks(3);
        #2 rst = 1'b1;
        #1 checkOutput("async_reset", 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        waitClocks(2);  checkOutput("post_reset_seed", 16'h0001);
        waitClocks(4);  checkOutput("post_reset_step", 16'h0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
